// File: rtl/spm_program_loader_if.sv
// -----------------------------------------------------------------------------
// spm_program_loader_if
//   Bundles the loader's byte-stream handshake and its memory write port.
//   slave  : the loader (consumes bytes, drives the memory write port)
//   master : the byte source / memory side
//   Signals: byte_valid, byte_data, byte_ready  (valid/ready byte stream)
//            mem_addr, mem_data, mem_write      (program memory write port)
// -----------------------------------------------------------------------------
interface spm_program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_write;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_addr, mem_data, mem_write
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_addr, mem_data, mem_write
  );
endinterface

// File: rtl/spm_program_loader.sv
// -----------------------------------------------------------------------------
// spm_program_loader
//   Streams a length-prefixed byte image into the 256x8 program memory from
//   address 0 while holding the CPU in reset, then releases it.
//   Stream format: N (0 means 2^ADDR_W), then N data bytes, then (optionally)
//   one checksum byte.
//   Optional feature macro: SPM_LOADER_CHECKSUM_EN -- adds a CSUM state; the
//   8-bit sum of length, data and checksum bytes must be 0x00, else the
//   loader parks in ERR with o_error=1 and the CPU still in reset.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        load request (honoured in IDLE or ERR only)
//   bus (slave)    byte stream in, memory write port out
//   o_cpu_rst      CPU reset hold (every state except IDLE)
//   o_busy         load in progress (not IDLE, not ERR)
//   o_done         one-cycle completion pulse
//   o_error        sticky checksum failure (0 without the macro)
// -----------------------------------------------------------------------------
module spm_program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  spm_program_loader_if.slave  bus,
  output logic                 o_cpu_rst,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  // One extra bit so a full 2^ADDR_W image length fits in the counter.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_DONE
`ifdef SPM_LOADER_CHECKSUM_EN
    , ST_CSUM,
    ST_ERR
`endif
  } state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_data;
  logic               r_mem_write;
  logic               w_ready;
  logic               w_xfer;
  logic               w_last;

  assign w_xfer = bus.byte_valid && w_ready;
  assign w_last = (r_cnt == CNT_W'(1));

`ifdef SPM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_chk;
  assign w_sum_chk = r_sum + 8'(bus.byte_data);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= '0;
    end else if (w_xfer) begin
      // The length byte restarts the sum; data bytes accumulate.
      if (r_state == ST_LEN)       r_sum <= 8'(bus.byte_data);
      else if (r_state == ST_DATA) r_sum <= w_sum_chk;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    o_cpu_rst = 1'b1;
    o_error   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy    = 1'b0;
        o_cpu_rst = 1'b0;
        if (i_start) w_next = ST_LEN;
      end
      ST_LEN: begin
        w_ready = 1'b1;
        if (w_xfer) w_next = ST_DATA;
      end
      ST_DATA: begin
        w_ready = 1'b1;
`ifdef SPM_LOADER_CHECKSUM_EN
        if (w_xfer && w_last) w_next = ST_CSUM;
`else
        if (w_xfer && w_last) w_next = ST_DONE;
`endif
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
`ifdef SPM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        w_ready = 1'b1;
        if (w_xfer) w_next = (w_sum_chk == 8'h00) ? ST_DONE : ST_ERR;
      end
      ST_ERR: begin
        o_busy  = 1'b0;
        o_error = 1'b1;
        if (i_start) w_next = ST_LEN;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Write port is registered: a byte accepted in DATA is written next cycle,
  // and address/data hold their last values between strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_write <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      if (w_xfer && r_state == ST_LEN) begin
        r_cnt  <= (bus.byte_data == '0) ? (CNT_W'(1) << ADDR_W)
                                        : CNT_W'(bus.byte_data);
        r_addr <= '0;
      end else if (w_xfer && r_state == ST_DATA) begin
        r_mem_write <= 1'b1;
        r_mem_addr  <= r_addr;
        r_mem_data  <= bus.byte_data;
        r_addr      <= r_addr + ADDR_W'(1);
        r_cnt       <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_data   = r_mem_data;
  assign bus.mem_write  = r_mem_write;

endmodule

// File: doc/spm_program_loader.md
Name: spm_program_loader

Overview:
- Write-side counterpart to the CPU's memory read path. Receives a byte stream over a valid/ready handshake and writes it into the 256x8 program memory, starting at address 0x00.
- Holds the processor in reset for the whole load, then releases it so execution starts from the freshly loaded image.
- Sits between an external byte source (host link or testbench) and the memory unit's write port (data, address, write). It is muxed onto that port while the loader is busy.

Parameters:
- ADDR_W, 8, memory address width; image length counts up to 2^ADDR_W bytes.
- DATA_W, 8, memory word and stream byte width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; ignored unless in IDLE or ERR.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  DATA_W  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  ADDR_W  write address to memory.
- mem_data  output  DATA_W  write data to memory.
- mem_write  output  1  memory write strobe, one cycle per data byte.
- cpu_rst  output  1  holds control and processing units in reset.
- busy  output  1  load in progress (any state other than IDLE or ERR).
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky checksum failure.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. Outputs byte_ready, mem_write, cpu_rst, busy, done and error are 0. mem_addr=0, mem_data=0, addr counter=0. Reset mid-load abandons the load immediately; memory keeps any bytes already written.
- Transfer rule: a byte transfers on a clock edge where byte_valid && byte_ready. byte_ready is combinational from state only: 1 in LEN, DATA and CSUM, 0 otherwise.
- IDLE: on start -> LEN, and cpu_rst=1 from the next cycle.
- ERR: on start -> LEN, and error is cleared.
- LEN: the first transferred byte is the length N. N=0 means 2^ADDR_W bytes. Load the remaining count, clear the addr counter to 0, then -> DATA.
- DATA: each transferred byte b produces, in the next cycle, mem_write=1, mem_addr=addr counter, mem_data=b. The counter then increments, wrapping from 0xFF to 0x00. mem_addr and mem_data hold their last values when mem_write=0.
- DATA exit: after the Nth byte -> CSUM if CHECKSUM_EN is defined, else -> DONE. The final mem_write pulse still occurs in the cycle after the last byte.
- DONE: lasts one cycle with done=1 and cpu_rst=1, then -> IDLE with cpu_rst=0. The first CPU instruction fetch sees all bytes written.
- Back-to-back bytes (byte_valid held high) give N writes in N consecutive cycles.
- A byte_valid gap causes no write and no counter change.
- start while busy: ignored.
- byte_valid in IDLE, DONE or ERR: not accepted, because byte_ready=0.

Optional Feature:
- Macro: SPM_LOADER_CHECKSUM_EN.
- When defined:
  - A running 8-bit sum mod 256 covers the length byte and all data bytes.
  - CSUM state accepts one more byte c.
  - If (sum+c) mod 256 == 0x00 -> DONE.
  - Else -> ERR: error=1, cpu_rst stays 1, busy=0, held until start or rst.
- When undefined: no CSUM state, no adder, error tied to 0, DATA goes directly to DONE.

Test Plan:
1. Basic load: reset, start, stream 0x03,0xA1,0xB2,0xC3 with valid held high -> writes (0x00,0xA1),(0x01,0xB2),(0x02,0xC3) on consecutive cycles. done pulses once, then cpu_rst falls to 0.
2. Gapped source: same image with byte_valid low for 2 cycles between data bytes -> exactly 3 mem_write pulses, addresses 0,1,2, no duplicate writes.
3. Full image: length 0x00, then 256 bytes with value i -> mem_write at addresses 0x00..0xFF, mem_data=i. Counter wraps to 0x00 with no extra write. done=1.
4. Checksum pass/fail (macro defined): 0x02,0x10,0x20 plus checksum 0xCE -> done=1, error=0. Repeat with 0xCF -> error=1 and cpu_rst stays 1. A following start clears error and a good load succeeds.
5. Reset mid-load: start, send 0x05,0x11,0x22, assert rst for one cycle -> all outputs 0 the next cycle. A subsequent full load writes from address 0x00.
6. Ignored inputs: pulse start during DATA and drive byte_valid=1 in IDLE -> no state change, byte_ready=0 in IDLE, no mem_write.
